// File: rtl/decode_top_pkg.sv
// ============================================================================
// Module      : decode_top_pkg
// Description : Shared types, opcodes and instruction field layout for the
//               decode stage (register file, scoreboard, ALU request).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_top_pkg;

    // Datapath and register-file geometry
    localparam int INSTR_WIDTH    = 32;
    localparam int PC_WIDTH       = 32;
    localparam int XLEN           = 32;
    localparam int NUM_REGS       = 32;
    localparam int REG_IDX_W      = $clog2(NUM_REGS);
    localparam int PEND_CNT_WIDTH = 2;

    // Instruction field ranges
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 20;
    localparam int RA_HI  = 19;
    localparam int RA_LO  = 15;
    localparam int RB_HI  = 14;
    localparam int RB_LO  = 10;
    localparam int IMM_HI = 14;
    localparam int BLO_HI = 9;

    // Opcodes
    localparam logic [6:0] C_OP_ADD      = 7'h00;
    localparam logic [6:0] C_OP_SUB      = 7'h01;
    localparam logic [6:0] C_OP_MUL      = 7'h02;
    localparam logic [6:0] C_OP_LDB      = 7'h10;
    localparam logic [6:0] C_OP_LDW      = 7'h11;
    localparam logic [6:0] C_OP_STB      = 7'h12;
    localparam logic [6:0] C_OP_STW      = 7'h13;
    localparam logic [6:0] C_OP_MOV      = 7'h14;
    localparam logic [6:0] C_OP_BEQ      = 7'h30;
    localparam logic [6:0] C_OP_JUMP     = 7'h31;
    localparam logic [6:0] C_OP_TLBWRITE = 7'h32;
    localparam logic [6:0] C_OP_IRET     = 7'h33;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [XLEN-1:0]     ra_val;
        logic [XLEN-1:0]     rb_val;
        logic [XLEN-1:0]     imm;
        logic [PC_WIDTH-1:0] pc;
        logic                writes_rd;
        logic                illegal_xcpt;
    } alu_request_t;

    function automatic logic op_is_legal(input logic [6:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_MUL, C_OP_LDB, C_OP_LDW, C_OP_STB,
            C_OP_STW, C_OP_MOV, C_OP_BEQ, C_OP_JUMP, C_OP_TLBWRITE,
            C_OP_IRET: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // ra is the first operand / base address / jump target
    function automatic logic op_uses_ra(input logic [6:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_MUL, C_OP_LDB, C_OP_LDW, C_OP_STB,
            C_OP_STW, C_OP_MOV, C_OP_BEQ, C_OP_JUMP,
            C_OP_TLBWRITE: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    // rb is the second ALU operand, store data, or compare operand
    function automatic logic op_uses_rb(input logic [6:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_MUL, C_OP_STB, C_OP_STW, C_OP_BEQ,
            C_OP_TLBWRITE: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic op_writes_rd(input logic [6:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_MUL, C_OP_LDB, C_OP_LDW,
            C_OP_MOV: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    // Branch-type instructions carry their offset split around the rd field
    function automatic logic op_is_branch(input logic [6:0] op);
        return (op == C_OP_BEQ) || (op == C_OP_JUMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_top_if.sv
// ============================================================================
// Module      : decode_top_if
// Description : Bus bundle around the decode stage: fetch input, stall/flush
//               control, writeback port and ALU request output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_top_if;
    import decode_top_pkg::*;

    logic                   fetch_instr_valid;
    logic [INSTR_WIDTH-1:0] fetch_instr_data;
    logic [PC_WIDTH-1:0]    fetch_instr_pc;
    logic                   stall_fetch;
    logic                   stall_decode;
    logic                   flush_decode;
    logic                   wb_valid;
    logic [4:0]             wb_dest;
    logic [XLEN-1:0]        wb_data;
    logic                   alu_req_valid;
    alu_request_t           alu_req_info;

    // Surrounding pipeline (fetch, execute, writeback)
    modport master (
        output fetch_instr_valid, fetch_instr_data, fetch_instr_pc,
        output stall_decode, flush_decode,
        output wb_valid, wb_dest, wb_data,
        input  stall_fetch, alu_req_valid, alu_req_info
    );

    // Decode stage
    modport slave (
        input  fetch_instr_valid, fetch_instr_data, fetch_instr_pc,
        input  stall_decode, flush_decode,
        input  wb_valid, wb_dest, wb_data,
        output stall_fetch, alu_req_valid, alu_req_info
    );

endinterface

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// ============================================================================
// Module      : decode_scoreboard
// Description : Per-register in-flight writer counters with summed
//               issue/writeback/flush updates and RAW/WAW hazard output.
//               Optional: DECODE_WB_BYPASS_EN discounts a same-cycle
//               writeback from the source hazard check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int PEND_CNT_WIDTH = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       instr_valid_i,
    input  wire logic [4:0] ra_idx_i,
    input  wire logic       ra_used_i,
    input  wire logic [4:0] rb_idx_i,
    input  wire logic       rb_used_i,
    input  wire logic [4:0] rd_idx_i,
    input  wire logic       rd_write_i,
    input  wire logic       inc_en_i,
    input  wire logic [4:0] inc_idx_i,
    input  wire logic       wb_en_i,
    input  wire logic [4:0] wb_idx_i,
    input  wire logic       flush_en_i,
    input  wire logic [4:0] flush_idx_i,
    output logic            hazard_o
);

    localparam logic [PEND_CNT_WIDTH-1:0] C_PEND_MAX = '1;
    localparam logic [PEND_CNT_WIDTH-1:0] C_ONE      = PEND_CNT_WIDTH'(1);

    logic [PEND_CNT_WIDTH-1:0] pend_q [NUM_REGS];
    logic [PEND_CNT_WIDTH-1:0] pend_d [NUM_REGS];
    logic [PEND_CNT_WIDTH-1:0] w_ra_pend;
    logic [PEND_CNT_WIDTH-1:0] w_rb_pend;
    logic                      w_underflow;

    // Net every register's increment and decrements into one update
    always_comb begin
        int v_net;
        v_net       = 0;
        w_underflow = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v_net = int'(pend_q[i]);
            if (inc_en_i && (int'(inc_idx_i) == i) && (i != 0)) begin
                v_net = v_net + 1;
            end
            if (wb_en_i && (int'(wb_idx_i) == i) && (i != 0)) begin
                v_net = v_net - 1;
            end
            if (flush_en_i && (int'(flush_idx_i) == i) && (i != 0)) begin
                v_net = v_net - 1;
            end
            if (v_net < 0) begin
                w_underflow = 1'b1;
                pend_d[i]   = '0;
            end else begin
                pend_d[i]   = PEND_CNT_WIDTH'(v_net);
            end
        end
    end

    // Pending counter state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    // Effective pending count seen by each source operand
    always_comb begin
        w_ra_pend = pend_q[ra_idx_i];
        w_rb_pend = pend_q[rb_idx_i];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_i && (wb_idx_i == ra_idx_i) && (w_ra_pend != '0)) begin
            w_ra_pend = w_ra_pend - C_ONE;
        end
        if (wb_en_i && (wb_idx_i == rb_idx_i) && (w_rb_pend != '0)) begin
            w_rb_pend = w_rb_pend - C_ONE;
        end
`endif
    end

    // RAW on any used non-zero source, WAW when rd's counter is saturated
    always_comb begin
        hazard_o = instr_valid_i & (
                   (ra_used_i  & (ra_idx_i != 5'd0) & (w_ra_pend != '0)) |
                   (rb_used_i  & (rb_idx_i != 5'd0) & (w_rb_pend != '0)) |
                   (rd_write_i & (pend_q[rd_idx_i] == C_PEND_MAX)));
    end

    // A writeback or flush with no tracked writer is a pipeline bug
    always @(posedge clock) begin
        if (reset) begin
            assert (!w_underflow);
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_top.sv
// ============================================================================
// Module      : decode_top
// Description : Decode stage. Register file, scoreboard-based hazard stall,
//               illegal-opcode detection and a registered ALU request.
//               Optional: DECODE_WB_BYPASS_EN forwards same-cycle writeback
//               data to the source operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_top
    import decode_top_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int PEND_CNT_WIDTH = 2
) (
    input  wire logic     clock,
    input  wire logic     reset,
    decode_top_if.slave   bus
);

    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic            req_valid_q;
    alu_request_t    req_q;
    alu_request_t    req_d;

    logic [6:0]      w_opc;
    logic [4:0]      w_rd;
    logic [4:0]      w_ra;
    logic [4:0]      w_rb;
    logic            w_legal;
    logic            w_ra_used;
    logic            w_rb_used;
    logic            w_writes;
    logic [XLEN-1:0] w_ra_val;
    logic [XLEN-1:0] w_rb_val;
    logic            w_wb_en;
    logic            w_flush_dec;
    logic            w_hazard;
    logic            w_issue;

    assign w_opc     = bus.fetch_instr_data[OPC_HI:OPC_LO];
    assign w_rd      = bus.fetch_instr_data[RD_HI:RD_LO];
    assign w_ra      = bus.fetch_instr_data[RA_HI:RA_LO];
    assign w_rb      = bus.fetch_instr_data[RB_HI:RB_LO];
    // Illegal instructions read and write nothing so they never stall
    assign w_legal   = op_is_legal(w_opc);
    assign w_ra_used = w_legal & op_uses_ra(w_opc);
    assign w_rb_used = w_legal & op_uses_rb(w_opc);
    assign w_writes  = w_legal & op_writes_rd(w_opc) & (w_rd != 5'd0);

    assign w_wb_en     = bus.wb_valid & (bus.wb_dest != 5'd0);
    // Killing the output entry releases the destination it had claimed
    assign w_flush_dec = bus.flush_decode & req_valid_q & req_q.writes_rd;
    assign w_issue     = bus.fetch_instr_valid & ~w_hazard &
                         ~bus.stall_decode & ~bus.flush_decode;

    assign bus.stall_fetch   = bus.stall_decode | w_hazard;
    assign bus.alu_req_valid = req_valid_q;
    assign bus.alu_req_info  = req_q;

    // Combinational operand read, r0 hard-wired to zero
    always_comb begin
        w_ra_val = '0;
        w_rb_val = '0;
        if (w_ra != 5'd0) begin
            w_ra_val = rf_q[w_ra];
`ifdef DECODE_WB_BYPASS_EN
            if (w_wb_en && (bus.wb_dest == w_ra)) begin
                w_ra_val = bus.wb_data;
            end
`endif
        end
        if (w_rb != 5'd0) begin
            w_rb_val = rf_q[w_rb];
`ifdef DECODE_WB_BYPASS_EN
            if (w_wb_en && (bus.wb_dest == w_rb)) begin
                w_rb_val = bus.wb_data;
            end
`endif
        end
    end

    // Build the request for the instruction fetch is presenting
    always_comb begin
        req_d              = '0;
        req_d.opcode       = w_opc;
        req_d.rd           = w_rd;
        req_d.ra_val       = w_ra_val;
        req_d.rb_val       = w_rb_val;
        req_d.pc           = bus.fetch_instr_pc;
        req_d.writes_rd    = w_writes;
        req_d.illegal_xcpt = ~w_legal;
        if (op_is_branch(w_opc)) begin
            req_d.imm = {{(XLEN-15){bus.fetch_instr_data[RD_HI]}},
                         bus.fetch_instr_data[RD_HI:RD_LO],
                         bus.fetch_instr_data[BLO_HI:0]};
        end else begin
            req_d.imm = {{(XLEN-15){bus.fetch_instr_data[IMM_HI]}},
                         bus.fetch_instr_data[IMM_HI:0]};
        end
    end

    // Architectural register file, written by the writeback port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_wb_en) begin
            rf_q[bus.wb_dest] <= bus.wb_data;
        end
    end

    // Output register: flush beats stall, stall holds, otherwise load/clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (bus.flush_decode) begin
            req_valid_q <= 1'b0;
        end else if (!bus.stall_decode) begin
            req_valid_q <= w_issue;
            if (w_issue) begin
                req_q <= req_d;
            end
        end
    end

    decode_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .PEND_CNT_WIDTH (PEND_CNT_WIDTH)
    ) u_sb (
        .clock         (clock),
        .reset         (reset),
        .instr_valid_i (bus.fetch_instr_valid),
        .ra_idx_i      (w_ra),
        .ra_used_i     (w_ra_used),
        .rb_idx_i      (w_rb),
        .rb_used_i     (w_rb_used),
        .rd_idx_i      (w_rd),
        .rd_write_i    (w_writes),
        .inc_en_i      (w_issue & w_writes),
        .inc_idx_i     (w_rd),
        .wb_en_i       (w_wb_en),
        .wb_idx_i      (bus.wb_dest),
        .flush_en_i    (w_flush_dec),
        .flush_idx_i   (req_q.rd),
        .hazard_o      (w_hazard)
    );

endmodule

`default_nettype wire

// File: tb/tb_decode_top.sv
// ============================================================================
// Module      : tb_decode_top
// Description : Directed self-checking bench for decode_top. Follows
//               DECODE_WB_BYPASS_EN for the forwarding-dependent timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_top;
    import decode_top_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_top_if bus ();

    decode_top dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 10'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.fetch_instr_valid = 1'b1;
        bus.fetch_instr_data  = instr;
        bus.fetch_instr_pc    = pc;
    endtask

    task automatic wb(input logic [4:0] dest, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_dest  = dest;
        bus.wb_data  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.fetch_instr_valid = 1'b0;
        bus.fetch_instr_data  = '0;
        bus.fetch_instr_pc    = '0;
        bus.stall_decode      = 1'b0;
        bus.flush_decode      = 1'b0;
        bus.wb_valid          = 1'b0;
        bus.wb_dest           = '0;
        bus.wb_data           = '0;

        // Reset state
        mid();
        chk("rst_valid", 64'(bus.alu_req_valid), 64'd0);
        chk("rst_info_zero", 64'(bus.alu_req_info === '0), 64'd1);
        chk("rst_stall", 64'(bus.stall_fetch), 64'd0);
        chk("rst_pend3", 64'(dut.u_sb.pend_q[3]), 64'd0);
        tick();
        rst_n = 1'b1;

        // Preload r1=5, r2=7: claim each with a MOV, then write it back
        tick();
        present(enc(C_OP_MOV, 5'd1, 5'd0, 5'd0), 32'h10);
        mid();
        chk("mov1_stall", 64'(bus.stall_fetch), 64'd0);
        tick();
        present(enc(C_OP_MOV, 5'd2, 5'd0, 5'd0), 32'h14);
        wb(5'd1, 32'd5);
        mid();
        chk("mov1_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("mov1_opc", 64'(bus.alu_req_info.opcode), 64'h14);
        chk("mov1_pend1", 64'(dut.u_sb.pend_q[1]), 64'd1);
        tick();
        bus.fetch_instr_valid = 1'b0;
        wb(5'd2, 32'd7);
        mid();
        chk("pre_pend1", 64'(dut.u_sb.pend_q[1]), 64'd0);
        chk("pre_pend2", 64'(dut.u_sb.pend_q[2]), 64'd1);

        // ADD r3,r1,r2
        tick();
        bus.wb_valid = 1'b0;
        present(enc(C_OP_ADD, 5'd3, 5'd1, 5'd2), 32'h100);
        mid();
        chk("add_stall", 64'(bus.stall_fetch), 64'd0);
        chk("pre_pend2_clr", 64'(dut.u_sb.pend_q[2]), 64'd0);

        // SUB r4,r3,r1 right behind it
        tick();
        present(enc(C_OP_SUB, 5'd4, 5'd3, 5'd1), 32'h104);
        mid();
        chk("add_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("add_ra", 64'(bus.alu_req_info.ra_val), 64'd5);
        chk("add_rb", 64'(bus.alu_req_info.rb_val), 64'd7);
        chk("add_rd", 64'(bus.alu_req_info.rd), 64'd3);
        chk("add_wr", 64'(bus.alu_req_info.writes_rd), 64'd1);
        chk("add_pc", 64'(bus.alu_req_info.pc), 64'h100);
        chk("add_pend3", 64'(dut.u_sb.pend_q[3]), 64'd1);
        chk("sub_raw_stall", 64'(bus.stall_fetch), 64'd1);
        tick();
        wb(5'd3, 32'h33);
        mid();
        chk("sub_wait_valid", 64'(bus.alu_req_valid), 64'd0);
`ifdef DECODE_WB_BYPASS_EN
        chk("sub_wbcyc_stall", 64'(bus.stall_fetch), 64'd0);
        tick();
        bus.wb_valid          = 1'b0;
        bus.fetch_instr_valid = 1'b0;
        mid();
`else
        chk("sub_wbcyc_stall", 64'(bus.stall_fetch), 64'd1);
        tick();
        bus.wb_valid = 1'b0;
        mid();
        chk("sub_after_stall", 64'(bus.stall_fetch), 64'd0);
        chk("sub_after_valid", 64'(bus.alu_req_valid), 64'd0);
        chk("sub_pend3", 64'(dut.u_sb.pend_q[3]), 64'd0);
        tick();
        bus.fetch_instr_valid = 1'b0;
        mid();
`endif
        chk("sub_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("sub_opc", 64'(bus.alu_req_info.opcode), 64'h01);
        chk("sub_ra", 64'(bus.alu_req_info.ra_val), 64'h33);
        chk("sub_rb", 64'(bus.alu_req_info.rb_val), 64'd5);
        chk("sub_rd", 64'(bus.alu_req_info.rd), 64'd4);
        chk("sub_pend4", 64'(dut.u_sb.pend_q[4]), 64'd1);

        // MOV r5 x4: the fourth hits the saturated counter
        tick();
        present(enc(C_OP_MOV, 5'd5, 5'd0, 5'd0), 32'h200);
        wb(5'd4, 32'h44);
        mid();
        chk("mov5_stall0", 64'(bus.stall_fetch), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        tick();
        wb(5'd5, 32'd9);
        mid();
        chk("mov5_waw_stall", 64'(bus.stall_fetch), 64'd1);
        chk("mov5_pend_max", 64'(dut.u_sb.pend_q[5]), 64'd3);
        chk("sub_pend4_clr", 64'(dut.u_sb.pend_q[4]), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        mid();
        chk("mov5_release", 64'(bus.stall_fetch), 64'd0);
        chk("mov5_pend2", 64'(dut.u_sb.pend_q[5]), 64'd2);
        chk("mov5_gap_valid", 64'(bus.alu_req_valid), 64'd0);
        tick();
        bus.fetch_instr_valid = 1'b0;
        mid();
        chk("mov5_4th_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("mov5_4th_rd", 64'(bus.alu_req_info.rd), 64'd5);
        chk("mov5_pend3", 64'(dut.u_sb.pend_q[5]), 64'd3);
        tick();
        wb(5'd5, 32'd1);
        tick();
        tick();
        tick();
        bus.wb_valid = 1'b0;
        mid();
        chk("mov5_drained", 64'(dut.u_sb.pend_q[5]), 64'd0);

        // Illegal opcode 0x7F
        tick();
        present(enc(7'h7F, 5'd7, 5'd3, 5'd4), 32'h300);
        mid();
        chk("ill_stall", 64'(bus.stall_fetch), 64'd0);
        tick();
        bus.fetch_instr_valid = 1'b0;
        mid();
        chk("ill_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("ill_xcpt", 64'(bus.alu_req_info.illegal_xcpt), 64'd1);
        chk("ill_wr", 64'(bus.alu_req_info.writes_rd), 64'd0);
        chk("ill_pend7", 64'(dut.u_sb.pend_q[7]), 64'd0);

        // Flush while stalled, ADD r6 held in the output register
        tick();
        present(enc(C_OP_ADD, 5'd6, 5'd1, 5'd2), 32'h400);
        tick();
        present(enc(C_OP_ADD, 5'd8, 5'd1, 5'd2), 32'h404);
        bus.stall_decode = 1'b1;
        mid();
        chk("fl_held_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("fl_held_rd", 64'(bus.alu_req_info.rd), 64'd6);
        chk("fl_pend6", 64'(dut.u_sb.pend_q[6]), 64'd1);
        chk("fl_stall_dec", 64'(bus.stall_fetch), 64'd1);
        tick();
        bus.flush_decode = 1'b1;
        mid();
        chk("fl_hold_valid", 64'(bus.alu_req_valid), 64'd1);
        tick();
        bus.flush_decode      = 1'b0;
        bus.stall_decode      = 1'b0;
        bus.fetch_instr_valid = 1'b0;
        mid();
        chk("fl_valid", 64'(bus.alu_req_valid), 64'd0);
        chk("fl_pend6_clr", 64'(dut.u_sb.pend_q[6]), 64'd0);
        chk("fl_pend8", 64'(dut.u_sb.pend_q[8]), 64'd0);

        // Writeback to r0 is discarded
        tick();
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        bus.wb_valid = 1'b0;
        present(enc(C_OP_ADD, 5'd1, 5'd0, 5'd0), 32'h500);
        mid();
        chk("r0_stall", 64'(bus.stall_fetch), 64'd0);
        chk("r0_pend0", 64'(dut.u_sb.pend_q[0]), 64'd0);
        tick();
        bus.fetch_instr_valid = 1'b0;
        mid();
        chk("r0_valid", 64'(bus.alu_req_valid), 64'd1);
        chk("r0_ra", 64'(bus.alu_req_info.ra_val), 64'd0);
        chk("r0_rb", 64'(bus.alu_req_info.rb_val), 64'd0);
        chk("r0_rd", 64'(bus.alu_req_info.rd), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
